// File: rtl/fifo_uart_tx.sv
// Pops WIDTH-bit words from a FIFO and sends them as WIDTH/8 UART frames, low byte first.
// Define UART_TX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx #(
  parameter int WIDTH        = 16,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_rd_en,
  output logic             tx,
  output logic             busy,
  output logic             tx_done
);

  localparam int NBYTES = WIDTH / 8;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t            state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_q;
  logic [BYTE_W-1:0] byte_q;
  logic [WIDTH-1:0]  shift_q;
  logic              tx_q;
  logic              done_q;
`ifdef UART_TX_PARITY_EN
  logic              parity_q;
`endif

  logic baud_tc;
  logic byte_last;

  assign baud_tc   = (baud_q == BAUD_LAST);
  assign byte_last = (byte_q == BYTE_LAST);

  // Combinational so the word is captured on the same edge that advances the FIFO.
  assign fifo_rd_en = reset_n & (state_q == ST_IDLE) & enable & ~fifo_empty;
  assign busy       = (state_q != ST_IDLE);
  assign tx         = tx_q;
  assign tx_done    = done_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (fifo_rd_en) begin
            shift_q <= fifo_rdata;
            byte_q  <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (baud_tc) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
`ifdef UART_TX_PARITY_EN
            parity_q <= ^shift_q[7:0];
`endif
            state_q <= ST_DATA;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        ST_DATA: begin
          if (baud_tc) begin
            baud_q  <= '0;
            // Shifting after the 8th bit also leaves the next byte's LSB at bit 0.
            shift_q <= shift_q >> 1;
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= parity_q;
              state_q <= ST_PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= ST_STOP;
`endif
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (baud_tc) begin
            baud_q  <= '0;
            tx_q    <= 1'b1;
            state_q <= ST_STOP;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
`endif
        ST_STOP: begin
          if (baud_tc) begin
            baud_q <= '0;
            if (byte_last) begin
              tx_q    <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              byte_q  <= byte_q + BYTE_W'(1);
              tx_q    <= 1'b0;
              state_q <= ST_START;
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
            // Raised one cycle early so the pulse lands in the final stop-bit cycle.
            if (byte_last && (baud_q == BAUD_PRE)) begin
              done_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx with a behavioural FIFO and a frame-level line model.
module tb_fifo_uart_tx;

  localparam int WIDTH = 16;
  localparam int CPB   = 4;
  localparam int NB    = WIDTH / 8;
`ifdef UART_TX_PARITY_EN
  localparam int F = 11;
`else
  localparam int F = 10;
`endif
  localparam int WORD_CYC = NB * F * CPB;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_rd_en;
  logic             tx;
  logic             busy;
  logic             tx_done;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pop_count = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_rdata = mem[rd_ptr % 64];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      rd_ptr    <= rd_ptr + 1;
      pop_count <= pop_count + 1;
    end
  end

  fifo_uart_tx #(
    .WIDTH(WIDTH),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata),
    .fifo_rd_en(fifo_rd_en),
    .tx(tx),
    .busy(busy),
    .tx_done(tx_done)
  );

  // Line level of serial bit k of a word: frames of start, 8 data LSB first, [parity], stop.
  function automatic logic exp_bit(input logic [WIDTH-1:0] w, input int k);
    int bi;
    int pos;
    logic [7:0] b;
    bi  = k / F;
    pos = k % F;
    b   = w[8*bi +: 8];
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    if (F == 11 && pos == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic push(input logic [WIDTH-1:0] w);
    mem[wr_ptr % 64] = w;
    wr_ptr++;
  endtask

  task automatic wait_pop(input string tag, input int max);
    int n;
    n = 0;
    #1;
    while (fifo_rd_en !== 1'b1 && n < max) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (fifo_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL %s pop: fifo_rd_en=%b after %0d cycles, required 1", tag, fifo_rd_en, n);
    end
  endtask

  // Follows one popped word cycle by cycle against the frame model.
  task automatic run_word(input logic [WIDTH-1:0] w, input string tag,
                          input int drop_at, input int abort_at);
    logic e;
    for (int c = 1; c <= WORD_CYC; c++) begin
      @(negedge clk);
      e = exp_bit(w, (c - 1) / CPB);
      checks++;
      if (tx !== e) begin
        errors++;
        $display("FAIL %s tx cycle %0d: got %b, required %b", tag, c, tx, e);
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy cycle %0d: got %b, required 1", tag, c, busy);
      end
      checks++;
      if (tx_done !== (c == WORD_CYC)) begin
        errors++;
        $display("FAIL %s tx_done cycle %0d: got %b, required %b", tag, c, tx_done, (c == WORD_CYC));
      end
      checks++;
      if (fifo_rd_en !== 1'b0) begin
        errors++;
        $display("FAIL %s rd_en cycle %0d: got %b, required 0", tag, c, fifo_rd_en);
      end
      if (c == drop_at) enable = 1'b0;
      if (c == abort_at) begin
        $display("word %h (%s) interrupted at cycle %0d", w, tag, c);
        return;
      end
    end
    $display("word %h (%s) transmitted", w, tag);
  endtask

  task automatic test_reset();
    enable = 1'b1;
    push(WIDTH'($urandom));
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset tx: got %b, required 1", tx); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b, required 0", busy); end
    checks++;
    if (tx_done !== 1'b0) begin errors++; $display("FAIL reset tx_done: got %b, required 0", tx_done); end
    checks++;
    if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset rd_en: got %b, required 0", fifo_rd_en); end
    reset_n = 1'b1;
    wait_pop("reset", 2);
    run_word(mem[0], "after_reset", 0, 0);
    @(negedge clk);
  endtask

  task automatic test_single_word();
    int pc;
    pc = pop_count;
    push(16'hA55A);
    wait_pop("single", 2);
    run_word(16'hA55A, "single", 0, 0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1 || fifo_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL single idle: busy=%b tx=%b rd_en=%b, required 0 1 0", busy, tx, fifo_rd_en);
    end
    checks++;
    if (pop_count - pc !== 1) begin
      errors++;
      $display("FAIL single pops: got %0d, required 1", pop_count - pc);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] w [3];
    for (int i = 0; i < 3; i++) begin
      w[i] = WIDTH'($urandom);
      push(w[i]);
    end
    wait_pop("b2b", 2);
    for (int i = 0; i < 3; i++) begin
      run_word(w[i], "b2b", 0, 0);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || tx !== 1'b1) begin
        errors++;
        $display("FAIL b2b gap %0d: busy=%b tx=%b, required 0 1", i, busy, tx);
      end
      checks++;
      if (fifo_rd_en !== (i < 2)) begin
        errors++;
        $display("FAIL b2b next pop %0d: rd_en=%b, required %b", i, fifo_rd_en, (i < 2));
      end
    end
  endtask

  task automatic test_empty();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      checks++;
      if (fifo_rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL empty cycle %0d: rd_en=%b tx=%b busy=%b, required 0 1 0", c, fifo_rd_en, tx, busy);
      end
    end
    $display("empty fifo idle for 100 cycles");
  endtask

  task automatic test_enable_drop();
    logic [WIDTH-1:0] w2;
    w2 = WIDTH'($urandom);
    enable = 1'b1;
    push(16'h1234);
    push(w2);
    wait_pop("en_drop", 2);
    run_word(16'h1234, "en_drop", 10, 0);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      checks++;
      if (fifo_rd_en !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) begin
        errors++;
        $display("FAIL en_drop hold %0d: rd_en=%b busy=%b tx=%b, required 0 0 1", c, fifo_rd_en, busy, tx);
      end
    end
    enable = 1'b1;
    wait_pop("en_resume", 1);
    run_word(w2, "en_resume", 0, 0);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] wa;
    logic [WIDTH-1:0] wb;
    int pc;
    wa = WIDTH'($urandom);
    wb = WIDTH'($urandom);
    push(wa);
    push(wb);
    wait_pop("rst_mid", 2);
    run_word(wa, "rst_mid", 0, CPB * 3 + 2);
    reset_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid async: tx=%b busy=%b rd_en=%b, required 1 0 0", tx, busy, fifo_rd_en);
    end
    @(negedge clk);
    reset_n = 1'b1;
    pc = pop_count;
    wait_pop("rst_release", 0);
    run_word(wb, "rst_release", 0, 0);
    @(negedge clk);
    checks++;
    if (pop_count - pc !== 1 || fifo_rd_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid resend: pops=%0d rd_en=%b busy=%b, required 1 0 0", pop_count - pc, fifo_rd_en, busy);
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] w;
    for (int i = 0; i < 5; i++) begin
      w = (i == 0) ? 16'h015B : WIDTH'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      push(w);
      wait_pop("random", 2);
      run_word(w, "random", 0, 0);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || tx !== 1'b1) begin
        errors++;
        $display("FAIL random idle %0d: busy=%b tx=%b, required 0 1", i, busy, tx);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_empty();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmit stage downstream of the team's 16-bit `fifo`. It pops one word at a time from the FIFO read port and sends it as WIDTH/8 consecutive UART frames, low byte first, each sent LSB first on a single `tx` line. It is the consumer side of the FIFO. Its FIFO-facing ports connect directly to `fifo.read_en`, `fifo.empty` and `fifo.data_out`.

## Interface
- `WIDTH`, 16: FIFO word width. Must be a multiple of 8 and at least 8.
- `CLKS_PER_BIT`, 16: clk cycles per serial bit. Must be at least 2.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous active-low reset.
- `enable` in 1: allows a new word to be popped. Does not abort a word already in progress.
- `fifo_empty` in 1: from `fifo.empty`.
- `fifo_rdata` in WIDTH: from `fifo.data_out`. Valid combinationally while `fifo_rd_en` is high.
- `fifo_rd_en` out 1: to `fifo.read_en`. A one-cycle pop strobe.
- `tx` out 1: serial line. Idles high.
- `busy` out 1: high while a word is being transmitted.
- `tx_done` out 1: one-cycle pulse at the end of a word's last stop bit.

## Operation
- States:
  - IDLE
  - START (1 bit, line 0)
  - DATA (8 bits, LSB first)
  - PARITY (1 bit, only when `UART_TX_PARITY_EN` is defined)
  - STOP (1 bit, line 1)
- `fifo_rd_en` = (state==IDLE) & `enable` & ~`fifo_empty`, forced 0 while `reset_n` is low. It is combinational so that `fifo_rdata` can be captured at the same edge that advances the FIFO pointer.
- At the pop edge:
  - the full word loads into the shift register;
  - the byte counter clears;
  - state goes to START.
- Baud counter counts 0..CLKS_PER_BIT-1. Each bit advances only on terminal count.
- Bit counter counts 0..7 in DATA.
- Byte counter counts 0..WIDTH/8-1.
- From STOP at terminal count:
  - if the byte counter is not at its last value: increment it, go to START. Bytes within a word have no idle gap.
  - else: go to IDLE and pulse `tx_done`.
- `busy` = (state != IDLE).
- Reset values: `tx`=1, `busy`=0, `tx_done`=0, `fifo_rd_en`=0, state IDLE, all counters 0.

## Timing
- `tx` is registered.
- Cycle P is the pop cycle. `tx` goes low from cycle P+1.
- A word occupies WIDTH/8 × F × CLKS_PER_BIT cycles, where F = 10 frame bits (11 with parity).
- `tx_done` is high in the last cycle of the final stop bit. The state is IDLE in the next cycle.
- Back-to-back words:
  - exactly one IDLE cycle between words, with `tx` high in that cycle;
  - the next `fifo_rd_en` falls in that IDLE cycle.
- `fifo_empty` high in IDLE: no pop; `tx` stays at 1.
- `enable` dropped mid-word: the current word completes, then the block waits in IDLE.
- `reset_n` asserted mid-frame:
  - `tx` goes to 1 immediately (asynchronously);
  - state goes to IDLE;
  - the popped word is discarded, not re-popped.
- A FIFO read is issued only when `fifo_empty` is low, so FIFO underflow is impossible.

## Configuration
- `UART_TX_PARITY_EN`:
  - When defined: an even-parity bit (XOR of the 8 data bits) is sent between DATA and STOP. F=11.
  - When undefined: no PARITY state; STOP follows DATA. F=10.

## Test plan
- Single word, CLKS_PER_BIT=4, WIDTH=16, parity off, FIFO holds 0xA55A:
  - one `fifo_rd_en` pulse;
  - `tx` sends 0,0,1,0,1,1,0,1,0,1 (byte 0x5A), then 0,1,0,1,0,0,1,0,1,1 (byte 0xA5), each bit held 4 cycles;
  - `busy` high for 80 cycles;
  - `tx_done` pulses once in the 80th cycle.
- Two words queued, CLKS_PER_BIT=4, parity off: `fifo_rd_en` pulses exactly 81 cycles apart; `tx` is high for one cycle between the words.
- FIFO empty, `enable`=1, for 100 cycles: `fifo_rd_en`=0, `tx`=1, `busy`=0 throughout.
- `enable` deasserted 10 cycles after a pop of 0x1234: the full 80-cycle word completes; no further pop occurs while `enable`=0.
- Parity on, word 0x015B: frames are 0,data(0x5B),1,1 and 0,data(0x01),1,1; each byte carries parity bit 1; `busy` high for 88 cycles.
- `reset_n` pulsed low during DATA of byte 0:
  - `tx`=1 and `busy`=0 immediately;
  - after release with the FIFO non-empty, the next word pops one cycle later;
  - the interrupted word is not resent.
